// File: rtl/mips_mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// opcode/funct field values, the ALUOp class passed to the ALU decoder
// and the ALU control codes driven onto the datapath.
package mips_mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_JUMP
    } state_t;

    // IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // IR[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// Combinational ALU decoder.
//   aluop      in  2  operation class chosen by the main FSM
//   funct      in  6  R-type function field
//   alucontrol out 3  ALU function code
//   funct_ok   out 1  funct is one of the supported R-type functions
// An unsupported funct falls back to add so the datapath stays benign.
module alu_decoder
    import mips_mc_controller_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        funct_ok
);

    logic [2:0] funct_code;

    always_comb begin
        funct_ok   = 1'b1;
        funct_code = ALU_ADD;
        case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_SLT:  funct_code = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_code;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit (Moore FSM, lw/sw/R-type/beq/addi/j).
//   iClk, iRstN          clock, asynchronous active-low reset
//   iOp, iFunct          instruction fields from the IR
//   iZero                ALU zero flag, only used in BRANCH
//   iMemReady            memory access completes in a cycle where it is 1
//   oPCEn .. oALUControl datapath controls
//   oIllegal             one-cycle pulse in DECODE for unsupported op/funct
// Outputs are decoded from the state register and the held IR fields;
// the only input qualifications are iMemReady in FETCH and iZero in BRANCH.
module mips_mc_controller
    import mips_mc_controller_pkg::*;
(
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [5:0]  iOp,
    input  logic [5:0]  iFunct,
    input  logic        iZero,
    input  logic        iMemReady,
    output logic        oPCEn,
    output logic        oIorD,
    output logic        oMemWrite,
    output logic        oIRWrite,
    output logic        oRegDst,
    output logic        oMemtoReg,
    output logic        oRegWrite,
    output logic        oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic [1:0]  oPCSrc,
    output logic [2:0]  oALUControl,
    output logic        oIllegal
);

    state_t state, state_nx;
    aluop_t aluop;
    logic   funct_ok;
    logic   op_ok;
    logic   pcen, memwrite, irwrite, regwrite, illegal;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (iFunct),
        .alucontrol (oALUControl),
        .funct_ok   (funct_ok)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= S_FETCH;
        else        state <= state_nx;
    end

    assign op_ok = iOp inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

    always_comb begin
        state_nx  = state;
        pcen      = 1'b0;
        oIorD     = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        oRegDst   = 1'b0;
        oMemtoReg = 1'b0;
        regwrite  = 1'b0;
        oALUSrcA  = 1'b0;
        oALUSrcB  = 2'b00;
        oPCSrc    = 2'b00;
        aluop     = ALUOP_ADD;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                oALUSrcB = 2'b01;
                pcen     = iMemReady;
                irwrite  = iMemReady;
                if (iMemReady) state_nx = S_DECODE;
            end
            S_DECODE: begin
                oALUSrcB = 2'b11;
                illegal  = !op_ok || (iOp == OP_RTYPE && !funct_ok);
                case (iOp)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_RTYPEEX;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
                    default:      state_nx = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = 2'b10;
                if (iOp == OP_SW)      state_nx = S_MEMWR;
                else if (iOp == OP_LW) state_nx = S_MEMRD;
                else                   state_nx = S_FETCH;
            end
            S_MEMRD: begin
                oIorD = 1'b1;
                if (iMemReady) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                oMemtoReg = 1'b1;
                regwrite  = 1'b1;
                state_nx  = S_FETCH;
            end
            S_MEMWR: begin
                oIorD    = 1'b1;
                memwrite = 1'b1;
                if (iMemReady) state_nx = S_FETCH;
            end
            S_RTYPEEX: begin
                oALUSrcA = 1'b1;
                aluop    = ALUOP_FUNCT;
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                // Shared by R-type (rd) and addi (rt); a bad funct suppresses the write.
                oRegDst  = (iOp == OP_RTYPE);
                regwrite = (iOp != OP_RTYPE) || funct_ok;
                state_nx = S_FETCH;
            end
            S_BRANCH: begin
                oALUSrcA = 1'b1;
                aluop    = ALUOP_SUB;
                oPCSrc   = 2'b01;
                pcen     = iZero;
                state_nx = S_FETCH;
            end
            S_ADDIEX: begin
                oALUSrcA = 1'b1;
                oALUSrcB = 2'b10;
                state_nx = S_ALUWB;
            end
            S_JUMP: begin
                oPCSrc   = 2'b10;
                pcen     = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // The state register already reads FETCH during reset, so only the
    // strobes need gating to kill writes the instant reset asserts.
    assign oPCEn     = pcen     & iRstN;
    assign oIRWrite  = irwrite  & iRstN;
    assign oRegWrite = regwrite & iRstN;
    assign oMemWrite = memwrite & iRstN;
    assign oIllegal  = illegal  & iRstN;

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110;

    logic iClk = 1'b0, iRstN = 1'b0;
    logic [5:0] iOp = '0, iFunct = '0;
    logic iZero = 1'b0, iMemReady = 1'b1;
    logic oPCEn, oIorD, oMemWrite, oIRWrite, oRegDst, oMemtoReg, oRegWrite, oALUSrcA;
    logic [1:0] oALUSrcB, oPCSrc;
    logic [2:0] oALUControl;
    logic oIllegal;

    mips_mc_controller dut (
        .iClk(iClk), .iRstN(iRstN), .iOp(iOp), .iFunct(iFunct), .iZero(iZero),
        .iMemReady(iMemReady), .oPCEn(oPCEn), .oIorD(oIorD), .oMemWrite(oMemWrite),
        .oIRWrite(oIRWrite), .oRegDst(oRegDst), .oMemtoReg(oMemtoReg),
        .oRegWrite(oRegWrite), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
        .oPCSrc(oPCSrc), .oALUControl(oALUControl), .oIllegal(oIllegal)
    );

    always #5 iClk = ~iClk;

    logic [15:0] obs;
    assign obs = {oPCEn, oIorD, oMemWrite, oIRWrite, oRegDst, oMemtoReg, oRegWrite,
                  oALUSrcA, oALUSrcB, oPCSrc, oALUControl, oIllegal};

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] W(input logic pcen, iord, mw, irw, rdst, m2r, rw, srca,
                                      input logic [1:0] srcb, pcsrc,
                                      input logic [2:0] alu, input logic ill);
        return {pcen, iord, mw, irw, rdst, m2r, rw, srca, srcb, pcsrc, alu, ill};
    endfunction

    // {supported, alu code}
    function automatic logic [3:0] fmap(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b101010: return {1'b1, 3'b111};
            default:   return {1'b0, 3'b010};
        endcase
    endfunction

    // ---------------- reference model: per-instruction cycle script -------------
    typedef struct { logic rdy; logic zero; logic [15:0] exp; } cyc_t;
    cyc_t q[$];

    task automatic put(input logic rdy, input logic zero, input logic [15:0] e);
        cyc_t c;
        c.rdy = rdy; c.zero = zero; c.exp = e;
        q.push_back(c);
    endtask

    task automatic model(input logic [5:0] op, input logic [5:0] funct, input int fwait, input int mwait);
        logic [3:0] fm;
        logic op_ok, z;
        fm = fmap(funct);
        op_ok = (op == RT) || (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI) || (op == JMP);
        for (int i = 0; i < fwait; i++) put(1'b0, 1'($urandom), W(0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0));
        put(1'b1, 1'($urandom), W(1,0,0,1,0,0,0,0,2'b01,2'b00,A_ADD,0));
        put(1'($urandom), 1'($urandom),
            W(0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD, !op_ok || (op == RT && !fm[3])));
        if (!op_ok) return;
        if (op == LW || op == SW) begin
            put(1'($urandom), 1'($urandom), W(0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0));
            for (int i = 0; i <= mwait; i++)
                put(i == mwait, 1'($urandom), W(0,1,op == SW,0,0,0,0,0,2'b00,2'b00,A_ADD,0));
            if (op == LW) put(1'($urandom), 1'($urandom), W(0,0,0,0,0,1,1,0,2'b00,2'b00,A_ADD,0));
        end else if (op == RT) begin
            put(1'($urandom), 1'($urandom), W(0,0,0,0,0,0,0,1,2'b00,2'b00,fm[2:0],0));
            put(1'($urandom), 1'($urandom), W(0,0,0,0,1,0,fm[3],0,2'b00,2'b00,A_ADD,0));
        end else if (op == BEQ) begin
            z = 1'($urandom);
            put(1'($urandom), z, W(z,0,0,0,0,0,0,1,2'b00,2'b01,A_SUB,0));
        end else if (op == ADDI) begin
            put(1'($urandom), 1'($urandom), W(0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0));
            put(1'($urandom), 1'($urandom), W(0,0,0,0,0,0,1,0,2'b00,2'b00,A_ADD,0));
        end else begin
            put(1'($urandom), 1'($urandom), W(1,0,0,0,0,0,0,0,2'b00,2'b10,A_ADD,0));
        end
    endtask

    // ---------------- table of whole-instruction expectations -------------------
    typedef struct {
        string name; logic [5:0] op; logic [5:0] funct; logic zero; int mwait;
        int lat; int rw; int pcen; int mw; int ill; int rdst; int m2r; logic [2:0] alu;
    } vec_t;
    vec_t vt[14];

    task automatic run_vec(input vec_t v);
        int lat, rw, pc, mw, il, rd, m2;
        logic [2:0] alu;
        lat = -1; rw = 0; pc = 0; mw = 0; il = 0; rd = 0; m2 = 0; alu = 3'bx;
        for (int c = 0; c < 30; c++) begin
            @(negedge iClk);
            if (c == 0) begin iOp = v.op; iFunct = v.funct; iZero = v.zero; end
            iMemReady = (c == 0) || ((v.op == LW || v.op == SW) && c == 3 + v.mwait);
            #1;
            // FETCH is the only state driving ALUSrcB=01; ready=0 keeps it parked there.
            if (c > 0 && oALUSrcB == 2'b01) begin lat = c; break; end
            if (c == 0) chk({v.name, " fetch irwrite"}, oIRWrite, 1);
            if (c == 2) alu = oALUControl;
            rw += oRegWrite; pc += oPCEn; mw += oMemWrite; il += oIllegal;
            rd += oRegDst; m2 += oMemtoReg;
        end
        chk({v.name, " latency"}, lat, v.lat);
        chk({v.name, " regwrite cnt"}, rw, v.rw);
        chk({v.name, " pcen cnt"}, pc, v.pcen);
        chk({v.name, " memwrite cnt"}, mw, v.mw);
        chk({v.name, " illegal cnt"}, il, v.ill);
        chk({v.name, " regdst cnt"}, rd, v.rdst);
        chk({v.name, " memtoreg cnt"}, m2, v.m2r);
        if (v.lat > 2) chk({v.name, " exec alu"}, alu, v.alu);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        cyc_t e;
        ops = '{LW, SW, RT, BEQ, ADDI, JMP};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        //           name        op          funct      z  mw lat rw pc mw il rd m2 alu
        vt[0]  = '{"lw",       LW,  6'b000000, 1'b0, 0, 5, 1, 1, 0, 0, 0, 1, 3'b010};
        vt[1]  = '{"sw wait3", SW,  6'b000000, 1'b0, 3, 7, 0, 1, 4, 0, 0, 0, 3'b010};
        vt[2]  = '{"add",      RT,  6'b100000, 1'b0, 0, 4, 1, 1, 0, 0, 1, 0, 3'b010};
        vt[3]  = '{"sub",      RT,  6'b100010, 1'b0, 0, 4, 1, 1, 0, 0, 1, 0, 3'b110};
        vt[4]  = '{"and",      RT,  6'b100100, 1'b0, 0, 4, 1, 1, 0, 0, 1, 0, 3'b000};
        vt[5]  = '{"or",       RT,  6'b100101, 1'b0, 0, 4, 1, 1, 0, 0, 1, 0, 3'b001};
        vt[6]  = '{"slt",      RT,  6'b101010, 1'b0, 0, 4, 1, 1, 0, 0, 1, 0, 3'b111};
        vt[7]  = '{"bad funct",RT,  6'b000111, 1'b0, 0, 4, 0, 1, 0, 1, 1, 0, 3'b010};
        vt[8]  = '{"beq z1",   BEQ, 6'b000000, 1'b1, 0, 3, 0, 2, 0, 0, 0, 0, 3'b110};
        vt[9]  = '{"beq z0",   BEQ, 6'b000000, 1'b0, 0, 3, 0, 1, 0, 0, 0, 0, 3'b110};
        vt[10] = '{"addi",     ADDI,6'b000000, 1'b0, 0, 4, 1, 1, 0, 0, 0, 0, 3'b010};
        vt[11] = '{"j",        JMP, 6'b000000, 1'b0, 0, 3, 0, 2, 0, 0, 0, 0, 3'b010};
        vt[12] = '{"bad op",   6'b111111, 6'b000000, 1'b0, 0, 2, 0, 1, 0, 1, 0, 0, 3'b010};
        vt[13] = '{"lw wait2", LW,  6'b000000, 1'b0, 2, 7, 1, 1, 0, 0, 0, 1, 3'b010};

        // reset state, with ready high to show the fetch strobes are held off
        #2;
        chk("reset outputs", obs, W(0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0));
        repeat (2) @(negedge iClk);
        chk("reset held outputs", obs, W(0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0));
        iRstN = 1'b1; iMemReady = 1'b0;

        foreach (vt[i]) run_vec(vt[i]);

        // reset asserted in the middle of a stalled store
        @(negedge iClk); iOp = SW; iMemReady = 1'b1;   // FETCH
        @(negedge iClk); iMemReady = 1'b0;             // DECODE
        @(negedge iClk);                               // MEMADR
        @(negedge iClk); #1;                           // MEMWR
        chk("memwr before reset", oMemWrite, 1);
        #2 iRstN = 1'b0; #1;
        chk("memwrite killed by reset", oMemWrite, 0);
        iMemReady = 1'b1; #1;
        chk("reset outputs mid-instr", obs, W(0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0));
        @(negedge iClk); #1;
        chk("reset still gates irwrite", oIRWrite, 0);
        @(negedge iClk); iRstN = 1'b1; iMemReady = 1'b0; #1;
        chk("fetch after release no ready", obs, W(0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0));
        @(negedge iClk); iMemReady = 1'b1; iOp = 6'b111111; #1;
        chk("fetch after release ready", obs, W(1,0,0,1,0,0,0,0,2'b01,2'b00,A_ADD,0));
        @(negedge iClk); iMemReady = 1'b0; #1;
        chk("illegal op decode", obs, W(0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD,1));

        // randomized instruction stream against the cycle-script model
        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            model(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
            while (q.size() > 0) begin
                e = q.pop_front();
                @(negedge iClk);
                iOp = op; iFunct = fn; iMemReady = e.rdy; iZero = e.zero;
                #1;
                chk($sformatf("rand op=%b fn=%b", op, fn), obs, e.exp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
